// File: rtl/branch_condition_unit_if.sv
// Bundles the flag, decode and pipeline-control signals of the branch condition unit.
// master drives the decode/flag inputs; slave is the branch condition unit itself.
interface branch_condition_unit_if;
  logic [3:0]  psr_flags;
  logic [3:0]  alu_flags;
  logic        alu_cc_we;
  logic        id_is_branch;
  logic [3:0]  cond;
  logic        annul;
  logic        stall;
  logic        branch_taken;
  logic        annul_slot;
  logic        in_delay_slot;
  logic [15:0] branch_count;
  logic [15:0] taken_count;

  modport master (
    output psr_flags, alu_flags, alu_cc_we, id_is_branch, cond, annul, stall,
    input  branch_taken, annul_slot, in_delay_slot, branch_count, taken_count
  );

  modport slave (
    input  psr_flags, alu_flags, alu_cc_we, id_is_branch, cond, annul, stall,
    output branch_taken, annul_slot, in_delay_slot, branch_count, taken_count
  );
endinterface

// File: rtl/branch_condition_unit.sv
// SPARC Bicc evaluation with same-cycle ALU flag forwarding and delay-slot annul control.
// Define BCU_STATS_EN to build the saturating branch/taken counters.
module branch_condition_unit (
  input  logic                   clk,
  input  logic                   Clr,
  branch_condition_unit_if.slave bus
);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t     state_q, state_d;
  logic       branch_taken_q, branch_taken_d;
  logic       annul_slot_q, annul_slot_d;
  logic       in_delay_slot_q, in_delay_slot_d;
  logic [3:0] eff;
  logic       z, c, n, v;
  logic       base_cond, cond_true, annul_now;

`ifdef BCU_STATS_EN
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;
`endif

  // Flag order is {Z, C, N, V}; the ALU's flags win when it writes the codes this cycle.
  assign eff = bus.alu_cc_we ? bus.alu_flags : bus.psr_flags;
  assign z   = eff[3];
  assign c   = eff[2];
  assign n   = eff[1];
  assign v   = eff[0];

  // The upper half of the cond encoding is the complement of the lower half.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    base_cond = 1'b0;
    case (bus.cond[2:0])
      3'd0: base_cond = 1'b0;
      3'd1: base_cond = z;
      3'd2: base_cond = z | (n ^ v);
      3'd3: base_cond = n ^ v;
      3'd4: base_cond = c | z;
      3'd5: base_cond = c;
      3'd6: base_cond = n;
      3'd7: base_cond = v;
      default: base_cond = 1'b0;
    endcase
    cond_true = bus.cond[3] ? ~base_cond : base_cond;
    // Only "branch always" annuls a taken slot; untaken branches annul whenever a=1.
    annul_now = cond_true ? (bus.annul && (bus.cond == 4'h8)) : bus.annul;
  end

  always_comb begin
    state_d         = state_q;
    branch_taken_d  = branch_taken_q;
    annul_slot_d    = annul_slot_q;
    in_delay_slot_d = in_delay_slot_q;
`ifdef BCU_STATS_EN
    branch_count_d  = branch_count_q;
    taken_count_d   = taken_count_q;
`endif
    if (!bus.stall) begin
      case (state_q)
        IDLE: begin
          branch_taken_d  = 1'b0;
          annul_slot_d    = 1'b0;
          in_delay_slot_d = 1'b0;
          if (bus.id_is_branch) begin
            state_d         = SLOT;
            branch_taken_d  = cond_true;
            annul_slot_d    = annul_now;
            in_delay_slot_d = 1'b1;
`ifdef BCU_STATS_EN
            if (branch_count_q != 16'hFFFF) branch_count_d = branch_count_q + 16'd1;
            if (cond_true && taken_count_q != 16'hFFFF) taken_count_d = taken_count_q + 16'd1;
`endif
          end
        end
        // A branch arriving here is a DCTI couple and is dropped without evaluation.
        SLOT: begin
          state_d         = IDLE;
          branch_taken_d  = 1'b0;
          annul_slot_d    = 1'b0;
          in_delay_slot_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (Clr) begin
      state_q         <= IDLE;
      branch_taken_q  <= 1'b0;
      annul_slot_q    <= 1'b0;
      in_delay_slot_q <= 1'b0;
`ifdef BCU_STATS_EN
      branch_count_q  <= 16'h0000;
      taken_count_q   <= 16'h0000;
`endif
    end else begin
      state_q         <= state_d;
      branch_taken_q  <= branch_taken_d;
      annul_slot_q    <= annul_slot_d;
      in_delay_slot_q <= in_delay_slot_d;
`ifdef BCU_STATS_EN
      branch_count_q  <= branch_count_d;
      taken_count_q   <= taken_count_d;
`endif
    end
  end

  assign bus.branch_taken  = branch_taken_q;
  assign bus.annul_slot    = annul_slot_q;
  assign bus.in_delay_slot = in_delay_slot_q;
`ifdef BCU_STATS_EN
  assign bus.branch_count  = branch_count_q;
  assign bus.taken_count   = taken_count_q;
`else
  assign bus.branch_count  = 16'h0000;
  assign bus.taken_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed vector bench for branch_condition_unit: condition table, forwarding, annul rules,
// DCTI couples, stall hold, reset priority and (with BCU_STATS_EN) counter behaviour.
module tb_branch_condition_unit;

  logic clk = 1'b0;
  logic Clr;
  int   checks = 0;
  int   errors = 0;
  int   exp_branches = 0;
  int   exp_taken = 0;

  branch_condition_unit_if bus ();

  branch_condition_unit dut (
    .clk (clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] psr;
    logic [3:0] alu;
    logic       we;
    logic [3:0] cond;
    logic       annul;
    logic       exp_taken;
    logic       exp_annul;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.psr_flags    = 4'h0;
    bus.alu_flags    = 4'h0;
    bus.alu_cc_we    = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.cond         = 4'h0;
    bus.annul        = 1'b0;
    bus.stall        = 1'b0;
  endtask

  task automatic drive_branch(input logic [3:0] psr, input logic [3:0] alu, input logic we,
                              input logic [3:0] cnd, input logic an);
    bus.psr_flags    = psr;
    bus.alu_flags    = alu;
    bus.alu_cc_we    = we;
    bus.cond         = cnd;
    bus.annul        = an;
    bus.id_is_branch = 1'b1;
  endtask

  task automatic check_outs(input string name, input logic t, input logic a, input logic s);
    check({name, ".taken"}, {15'd0, bus.branch_taken}, {15'd0, t});
    check({name, ".annul"}, {15'd0, bus.annul_slot}, {15'd0, a});
    check({name, ".slot"},  {15'd0, bus.in_delay_slot}, {15'd0, s});
  endtask

  task automatic check_counts(input string name);
`ifdef BCU_STATS_EN
    check({name, ".branch_count"}, bus.branch_count, exp_branches[15:0]);
    check({name, ".taken_count"},  bus.taken_count,  exp_taken[15:0]);
`else
    check({name, ".branch_count"}, bus.branch_count, 16'h0000);
    check({name, ".taken_count"},  bus.taken_count,  16'h0000);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          psr      alu      we    cond  an    taken annul
    vecs[0]  = '{4'b0000, 4'b1000, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0}; // BE, forwarded Z
    vecs[1]  = '{4'b0000, 4'b1000, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0}; // BE, committed flags
    vecs[2]  = '{4'b0000, 4'b0000, 1'b0, 4'h8, 1'b1, 1'b1, 1'b1}; // BA,a
    vecs[3]  = '{4'b0000, 4'b0000, 1'b0, 4'h9, 1'b1, 1'b1, 1'b0}; // BNE,a taken
    vecs[4]  = '{4'b1000, 4'b0000, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1}; // BNE,a untaken
    vecs[5]  = '{4'b0010, 4'b0000, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0}; // BL, N=1 V=0
    vecs[6]  = '{4'b0010, 4'b0000, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0}; // BGE, N=1 V=0
    vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1}; // BN,a
    vecs[8]  = '{4'b0100, 4'b0000, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0}; // BLEU, C
    vecs[9]  = '{4'b0100, 4'b0000, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0}; // BGU, C
    vecs[10] = '{4'b0011, 4'b0000, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0}; // BLE, N=V Z=0
    vecs[11] = '{4'b0000, 4'b0001, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0}; // BVS,a forwarded V
    vecs[12] = '{4'b0001, 4'b0000, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1}; // BVC,a untaken
    vecs[13] = '{4'b0100, 4'b0000, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0}; // BCS, ALU clears C
    vecs[14] = '{4'b0000, 4'b0000, 1'b0, 4'hE, 1'b1, 1'b1, 1'b0}; // BPOS,a

    // Reset wins over a simultaneous branch.
    idle_inputs();
    Clr = 1'b1;
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b1);
    step();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    Clr = 1'b0;
    bus.id_is_branch = 1'b0;
    step();
    check_outs("reset_idle", 1'b0, 1'b0, 1'b0);
    check_counts("reset");

    // Clr while in SLOT drops the pending pulse.
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b1);
    step();
    bus.id_is_branch = 1'b0;
    check_outs("pre_clr_slot", 1'b1, 1'b1, 1'b1);
    Clr = 1'b1;
    bus.stall = 1'b1;
    step();
    check_outs("clr_in_slot", 1'b0, 1'b0, 1'b0);
    Clr = 1'b0;
    bus.stall = 1'b0;
    check_counts("clr_in_slot");

    for (int i = 0; i < 15; i++) begin
      drive_branch(vecs[i].psr, vecs[i].alu, vecs[i].we, vecs[i].cond, vecs[i].annul);
      step();
      idle_inputs();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_taken, vecs[i].exp_annul, 1'b1);
      exp_branches++;
      if (vecs[i].exp_taken) exp_taken++;
      step();
      check_outs($sformatf("vec%0d_clear", i), 1'b0, 1'b0, 1'b0);
    end
    check_counts("table");

    // DCTI couple: second branch arrives in SLOT and is ignored.
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b0);
    step();
    check_outs("dcti_first", 1'b1, 1'b0, 1'b1);
    exp_branches++;
    exp_taken++;
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b1);
    step();
    idle_inputs();
    check_outs("dcti_second", 1'b0, 1'b0, 1'b0);
    step();
    check_outs("dcti_after", 1'b0, 1'b0, 1'b0);
    check_counts("dcti");

    // Stall in SLOT holds outputs for three cycles.
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b1);
    step();
    idle_inputs();
    exp_branches++;
    exp_taken++;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_outs($sformatf("stall_hold%0d", k), 1'b1, 1'b1, 1'b1);
    end
    bus.stall = 1'b0;
    step();
    check_outs("stall_release", 1'b0, 1'b0, 1'b0);

    // Stall in IDLE: branch is not taken up and not counted.
    drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b1);
    bus.stall = 1'b1;
    step();
    check_outs("stall_idle", 1'b0, 1'b0, 1'b0);
    idle_inputs();
    step();
    check_outs("stall_idle_after", 1'b0, 1'b0, 1'b0);
    check_counts("final");

`ifdef BCU_STATS_EN
    // Saturation: preload both counters just below the top.
    force dut.branch_count_q = 16'hFFFE;
    force dut.taken_count_q  = 16'hFFFE;
    #1;
    release dut.branch_count_q;
    release dut.taken_count_q;
    for (int k = 0; k < 3; k++) begin
      drive_branch(4'h0, 4'h0, 1'b0, 4'h8, 1'b0);
      step();
      idle_inputs();
      step();
    end
    check("sat.branch_count", bus.branch_count, 16'hFFFF);
    check("sat.taken_count",  bus.taken_count,  16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_condition_unit.md
# branch_condition_unit

- Evaluates SPARC Bicc conditions against the integer condition codes.
- Drives the PC-select and delay-slot annul signals for the fetch/decode stages.
- Sits directly downstream of the PSR register and consumes its committed flags.
- Forwards the ALU's in-flight flags when the instruction immediately ahead writes the condition codes, so a branch never sees stale flags.

## Interface
Flag vector order, fixed everywhere in this block: bit3 = Z, bit2 = C, bit1 = N, bit0 = V.

Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on the rising edge
- Clr  in  1  reset, synchronous and active-high
- psr_flags  in  4  committed flags from the PSR register
- alu_flags  in  4  flags produced by the ALU this cycle
- alu_cc_we  in  1  ALU instruction this cycle updates the condition codes
- id_is_branch  in  1  valid Bicc in decode this cycle
- cond  in  4  Bicc cond field
- annul  in  1  Bicc annul (a) bit
- stall  in  1  pipeline hold
- branch_taken  out  1  registered; select branch target for the next fetch
- annul_slot  out  1  registered; squash the delay-slot instruction
- in_delay_slot  out  1  registered; high while the FSM is in SLOT
- branch_count  out  16  branches evaluated (see Configuration)
- taken_count  out  16  branches taken (see Configuration)

## Operation
- Effective flags: `eff = alu_cc_we ? alu_flags : psr_flags`.
- Condition, by cond value:
  - 0 never; 1 Z; 2 Z|(N^V); 3 N^V
  - 4 C|Z; 5 C; 6 N; 7 V
  - 8 always; 9 !Z; A !(Z|(N^V)); B !(N^V)
  - C !(C|Z); D !C; E !N; F !V
- Annul rules:
  - taken & !annul → execute slot
  - taken & annul & cond==8 → annul slot
  - taken & annul & cond!=8 → execute slot
  - not taken & annul → annul slot
  - not taken & !annul → execute slot
- FSM states: IDLE, SLOT.
  - IDLE, id_is_branch & !stall → SLOT. Register branch_taken and annul_slot per the rules above; in_delay_slot=1.
  - SLOT, !stall → IDLE. Clear all three outputs.
  - SLOT, id_is_branch (DCTI couple) → the branch is ignored. Not evaluated, not counted, outputs still clear.
  - Any state, stall=1 → state, outputs and counters hold.
- Clr has priority over everything. Next edge: state=IDLE, branch_taken=0, annul_slot=0, in_delay_slot=0, counters=0.

## Timing
- Latency: branch sampled at edge N; outputs valid from edge N through edge N+1, one cycle absent stall. Stall extends the hold.
- Forwarding is same-cycle combinational: alu_flags present with alu_cc_we at edge N are used for a branch sampled at edge N.
- alu_cc_we=1 with id_is_branch=0 has no effect; the block never stores flags.
- Back-to-back branches on consecutive non-stall cycles: the second one lands in SLOT and is ignored.
- Clr and id_is_branch at the same edge: reset wins, and the branch is lost.
- Clr while in SLOT: returns to IDLE; the pending taken/annul pulse is dropped.
- Outputs never glitch mid-cycle, since all are flop outputs.

## Configuration
- Macro: `BCU_STATS_EN`.
- Defined:
  - branch_count increments on every evaluated branch (IDLE, id_is_branch, !stall).
  - taken_count increments when that branch's condition is true.
  - Both are 16-bit, saturate at 16'hFFFF and clear on Clr.
- Undefined: counters are not built; branch_count and taken_count are tied to 16'h0000.
- The FSM and outputs behave identically either way.

## Test plan
- Reset: Clr=1 one edge with id_is_branch=1, cond=8 → all outputs 0, state IDLE, counters 0.
- Forwarding:
  - psr_flags=4'b0000, alu_flags=4'b1000 (Z), alu_cc_we=1, cond=1 (BE), annul=0 → branch_taken=1, annul_slot=0 next cycle.
  - Same with alu_cc_we=0 → branch_taken=0.
- Annul rules:
  - cond=8, annul=1 → taken=1, annul_slot=1.
  - cond=9, flags Z=0, annul=1 → taken=1, annul_slot=0.
  - cond=9, flags Z=1, annul=1 → taken=0, annul_slot=1.
- Signed compare: flags N=1, V=0, cond=3 (BL) → taken=1; same flags, cond=B (BGE) → taken=0.
- DCTI couple and stall:
  - Branch then branch on the next cycle → second branch ignored, outputs 0 after SLOT.
  - stall=1 during SLOT for 3 cycles → outputs held for 3 cycles, then cleared.
- Stats (`BCU_STATS_EN` defined):
  - 5 branches, 3 taken → branch_count=5, taken_count=3.
  - Preload near 16'hFFFF → count saturates at 16'hFFFF, no wrap.
